sha2_miner_ctrl: RTL
====================

SHA2_MINER_CTRL -- requirements
Module: sha2_miner_ctrl

Interface
REQ-001 Parameter CORE_ROUNDS, default 2: rounds per cycle, passed to the sha2_chunk NUM_ROUNDS parameter.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 job_valid / job_ready  in/out  1/1  job handshake; transfer occurs when both are high on a rising edge.
REQ-005 job_header  in  640  80-byte block header, byte 0 at [639:632]; bytes 76..79 (nonce field) are ignored.
REQ-006 job_nonce_start, job_nonce_end  in  32/32  inclusive nonce range.
REQ-007 job_target  in  256  threshold compared against the hash value.
REQ-008 abort  in  1  cancels the current job.
REQ-009 res_valid / res_ready  out/in  1/1  result handshake.
REQ-010 res_found  out  1  1 = nonce found; 0 = range exhausted.
REQ-011 res_nonce  out  32  winning nonce, or last nonce tried.
REQ-012 res_hash  out  256  byte-reversed final digest of res_nonce.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, MID, SCAN1, SCAN2, CHECK, REPORT.
REQ-015 job_ready SHALL be 1 only in IDLE.
REQ-016 On job transfer, latch all job fields, set nonce = job_nonce_start, and go to MID.
REQ-017 If the range is empty (job_nonce_start > job_nonce_end), go directly to REPORT with res_found=0, res_nonce=job_nonce_start, res_hash=0.
REQ-018 Core phase protocol: drive the core chunk and h inputs stable, hold core start high until core done is sampled high, latch h_out that cycle, then hold start low exactly one cycle (gap) before the next phase.
REQ-019 MID: hash bytes 0..63 with the SHA-256 IV; latch the result as midstate. This phase runs once per job.
REQ-020 SCAN1: chunk = header bytes 64..75 (words 0..2), bswap32(nonce) (word 3), 0x80000000, ten zero words, 0x00000280; h = midstate.
REQ-021 SCAN2: chunk = SCAN1 digest h0..h7, 0x80000000, six zero words, 0x00000100; h = IV.
REQ-022 CHECK (1 cycle): hash value = byte-reverse of {h0..h7} from SCAN2. If hash value <= job_target (unsigned 256-bit), go to REPORT with res_found=1.
REQ-023 Else, if nonce == job_nonce_end, go to REPORT with res_found=0. Nonce SHALL NOT wrap: 0xFFFFFFFF as end stops the scan.
REQ-024 Else, nonce increments by 1 and the state returns to SCAN1. The midstate is not recomputed.
REQ-025 REPORT: res_valid=1 and res_* held stable until res_ready; then go to IDLE. A found result while res_ready is low stalls the scan.
REQ-026 abort sampled high in any non-IDLE state: go to IDLE next cycle, pulse core reset for one cycle, drop start, no result. abort has priority over res_ready.
REQ-027 abort in IDLE is ignored. A job_valid in the same cycle as abort in IDLE is accepted.
REQ-028 Throughput is one nonce per 2x(core latency + 1 gap) + 1 cycles.

Reset
REQ-029 With reset_n low at a rising edge: state=IDLE, job_ready=0 during reset, res_valid=0, res_found=0, res_nonce=0, res_hash=0, busy=0.
REQ-030 Reset also holds core start=0 and core reset=1. The first cycle after release has job_ready=1.
REQ-031 Reset mid-job discards all state; no result is emitted.

Structure
REQ-032 Shared package sha2_pkg SHALL hold: the SHA-256 IV constants; the padding words 0x80000000, 0x00000280 and 0x00000100; the state enum; and the bswap32/bswap256 functions.
REQ-033 Exactly one sub-module: one sha2_chunk instance (the core), driven only per REQ-018.

Verification
REQ-034 Genesis header, range 0x7C2BAC1B..0x7C2BAC1F, target 0x00000000FFFF followed by 208 zero bits -> res_found=1, res_nonce=0x7C2BAC1D, res_hash=0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
REQ-035 Any header, start=end=0xFFFFFFFF, target=0 -> exactly one nonce hashed, res_found=0, res_nonce=0xFFFFFFFF, no wrap.
REQ-036 start=5, end=4 -> REPORT within 2 cycles, res_found=0, zero core start pulses.
REQ-037 Target all-ones, range 10..20 -> res_found=1, res_nonce=10; res_ready held low 50 cycles -> outputs stable, busy=1.
REQ-038 abort during SCAN2 -> IDLE next cycle, core reset pulse observed, res_valid never high; the next genesis job still passes REQ-034.
REQ-039 reset_n low mid-SCAN1 -> all outputs at their REQ-029 values on the next edge.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-256 constants, controller state encoding and byte-order helpers
// for the nonce-scanning miner controller and its compression core.
package sha2_pkg;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] PAD_ONE     = 32'h80000000;
    localparam logic [31:0] PAD_LEN_80B = 32'h00000280;
    localparam logic [31:0] PAD_LEN_32B = 32'h00000100;

    localparam logic [31:0] SHA256_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        ST_IDLE, ST_MID, ST_SCAN1, ST_SCAN2, ST_CHECK, ST_REPORT
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CORE_IDLE, CORE_RUN, CORE_DONE
    } core_state_e;

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] y;
        y = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            y[8*i +: 8] = x[255-8*i -: 8];
        end
        return y;
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha2_chunk.sv
// Iterative SHA-256 compression of one 512-bit chunk, NUM_ROUNDS rounds per
// clock. done stays high with h_out valid until start is dropped.
module sha2_chunk
    import sha2_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] chunk,
    input  logic [255:0] h_in,
    output logic         done,
    output logic [255:0] h_out
);

    core_state_e  state_q, state_d;
    logic [6:0]   t_q, t_d;
    logic [255:0] wv_q, wv_d;
    logic [255:0] hb_q, hb_d;
    logic [255:0] hout_q, hout_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];

    logic [31:0]  rnd_v [8];
    logic [31:0]  rnd_w [16];
    logic [31:0]  t1, t2, wn;

    // NUM_ROUNDS unrolled rounds; the schedule is a 16-word sliding window
    always_comb begin
        for (int unsigned j = 0; j < 8; j++) begin
            rnd_v[j] = wv_q[255-32*j -: 32];
        end
        rnd_w = w_q;
        t1    = '0;
        t2    = '0;
        wn    = '0;
        for (int unsigned r = 0; r < NUM_ROUNDS; r++) begin
            t1 = rnd_v[7] + big_sigma1(rnd_v[4])
               + ((rnd_v[4] & rnd_v[5]) ^ (~rnd_v[4] & rnd_v[6]))
               + SHA256_K[6'(t_q + 7'(r))] + rnd_w[0];
            t2 = big_sigma0(rnd_v[0])
               + ((rnd_v[0] & rnd_v[1]) ^ (rnd_v[0] & rnd_v[2]) ^ (rnd_v[1] & rnd_v[2]));
            wn = small_sigma1(rnd_w[14]) + rnd_w[9] + small_sigma0(rnd_w[1]) + rnd_w[0];
            for (int unsigned j = 7; j > 0; j--) begin
                rnd_v[j] = rnd_v[j-1];
            end
            rnd_v[4] = rnd_v[4] + t1;
            rnd_v[0] = t1 + t2;
            for (int unsigned j = 0; j < 15; j++) begin
                rnd_w[j] = rnd_w[j+1];
            end
            rnd_w[15] = wn;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        wv_d    = wv_q;
        hb_d    = hb_q;
        hout_d  = hout_q;
        w_d     = w_q;
        unique case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    for (int unsigned j = 0; j < 16; j++) begin
                        w_d[j] = chunk[511-32*j -: 32];
                    end
                    wv_d    = h_in;
                    hb_d    = h_in;
                    t_d     = '0;
                    state_d = CORE_RUN;
                end
            end
            CORE_RUN: begin
                w_d = rnd_w;
                for (int unsigned j = 0; j < 8; j++) begin
                    wv_d[255-32*j -: 32] = rnd_v[j];
                end
                t_d = t_q + 7'(NUM_ROUNDS);
                if (t_q + 7'(NUM_ROUNDS) >= 7'd64) begin
                    for (int unsigned j = 0; j < 8; j++) begin
                        hout_d[255-32*j -: 32] = hb_q[255-32*j -: 32] + rnd_v[j];
                    end
                    state_d = CORE_DONE;
                end
            end
            CORE_DONE: begin
                if (!start) begin
                    state_d = CORE_IDLE;
                end
            end
            default: state_d = CORE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CORE_IDLE;
        end else begin
            state_q <= state_d;
        end
        t_q    <= t_d;
        wv_q   <= wv_d;
        hb_q   <= hb_d;
        hout_q <= hout_d;
        w_q    <= w_d;
    end

    assign done  = (state_q == CORE_DONE);
    assign h_out = hout_q;

endmodule

// File: rtl/sha2_miner_ctrl.sv
// Bitcoin-style nonce scanner: one midstate per job, then double SHA-256 per
// nonce on a shared compression core until a hash meets the target.
module sha2_miner_ctrl
    import sha2_pkg::*;
#(
    parameter int unsigned CORE_ROUNDS = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [639:0] job_header,
    input  logic [31:0]  job_nonce_start,
    input  logic [31:0]  job_nonce_end,
    input  logic [255:0] job_target,
    input  logic         abort,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_found,
    output logic [31:0]  res_nonce,
    output logic [255:0] res_hash,
    output logic         busy
);

    ctrl_state_e  state_q, state_d;
    logic         start_q, start_d;
    logic         core_rst_q, core_rst_d;
    logic [607:0] hdr_q, hdr_d;
    logic [31:0]  nonce_q, nonce_d;
    logic [31:0]  end_q, end_d;
    logic [255:0] target_q, target_d;
    logic [255:0] mid_q, mid_d;
    logic [255:0] dig_q, dig_d;
    logic         res_found_q, res_found_d;
    logic [31:0]  res_nonce_q, res_nonce_d;
    logic [255:0] res_hash_q, res_hash_d;

    logic [511:0] core_chunk;
    logic [255:0] core_h_in;
    logic         core_done;
    logic [255:0] core_h_out;
    logic [255:0] hash_val;
    logic         unused_nonce_field;

    assign unused_nonce_field = ^job_header[31:0];
    assign hash_val           = bswap256(dig_q);

    always_comb begin
        core_chunk = '0;
        core_h_in  = SHA256_IV;
        unique case (state_q)
            ST_MID:   core_chunk = hdr_q[607:96];
            ST_SCAN1: begin
                core_chunk = {hdr_q[95:0], bswap32(nonce_q), PAD_ONE, 320'd0, PAD_LEN_80B};
                core_h_in  = mid_q;
            end
            ST_SCAN2: core_chunk = {dig_q, PAD_ONE, 192'd0, PAD_LEN_32B};
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        core_rst_d  = 1'b0;
        hdr_d       = hdr_q;
        nonce_d     = nonce_q;
        end_d       = end_q;
        target_d    = target_q;
        mid_d       = mid_q;
        dig_d       = dig_q;
        res_found_d = res_found_q;
        res_nonce_d = res_nonce_q;
        res_hash_d  = res_hash_q;
        unique case (state_q)
            ST_IDLE: begin
                start_d = 1'b0;
                if (job_valid) begin
                    hdr_d    = job_header[639:32];
                    nonce_d  = job_nonce_start;
                    end_d    = job_nonce_end;
                    target_d = job_target;
                    if (job_nonce_start > job_nonce_end) begin
                        res_found_d = 1'b0;
                        res_nonce_d = job_nonce_start;
                        res_hash_d  = '0;
                        state_d     = ST_REPORT;
                    end else begin
                        state_d = ST_MID;
                    end
                end
            end
            // Each phase enters with start low: that cycle is the inter-phase gap
            ST_MID, ST_SCAN1, ST_SCAN2: begin
                if (!start_q) begin
                    start_d = 1'b1;
                end else if (core_done) begin
                    start_d = 1'b0;
                    if (state_q == ST_MID) begin
                        mid_d   = core_h_out;
                        state_d = ST_SCAN1;
                    end else if (state_q == ST_SCAN1) begin
                        dig_d   = core_h_out;
                        state_d = ST_SCAN2;
                    end else begin
                        dig_d   = core_h_out;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                res_nonce_d = nonce_q;
                res_hash_d  = hash_val;
                if (hash_val <= target_q) begin
                    res_found_d = 1'b1;
                    state_d     = ST_REPORT;
                end else if (nonce_q == end_q) begin
                    res_found_d = 1'b0;
                    state_d     = ST_REPORT;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = ST_SCAN1;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && state_q != ST_IDLE) begin
            state_d    = ST_IDLE;
            start_d    = 1'b0;
            core_rst_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            core_rst_q  <= 1'b1;
            res_found_q <= 1'b0;
            res_nonce_q <= '0;
            res_hash_q  <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            core_rst_q  <= core_rst_d;
            res_found_q <= res_found_d;
            res_nonce_q <= res_nonce_d;
            res_hash_q  <= res_hash_d;
        end
        hdr_q    <= hdr_d;
        nonce_q  <= nonce_d;
        end_q    <= end_d;
        target_q <= target_d;
        mid_q    <= mid_d;
        dig_q    <= dig_d;
    end

    sha2_chunk #(
        .NUM_ROUNDS(CORE_ROUNDS)
    ) u_core (
        .clk   (clk),
        .rst   (core_rst_q),
        .start (start_q),
        .chunk (core_chunk),
        .h_in  (core_h_in),
        .done  (core_done),
        .h_out (core_h_out)
    );

    assign job_ready = (state_q == ST_IDLE) && reset_n;
    assign res_valid = (state_q == ST_REPORT);
    assign res_found = res_found_q;
    assign res_nonce = res_nonce_q;
    assign res_hash  = res_hash_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
